vram_arbiter: RTL and testbench

// Shares the single-port 8 KB video RAM between the CPU bus and the VGA byte fetcher.

---
 rtl/vram_arbiter_pkg.sv | 17 +
 rtl/vram_arbiter.sv | 136 +++++++++++++
 tb/tb_vram_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the video RAM arbiter: default widths, the CPU
// starvation limit and the 3-bit FSM state encoding.
package vram_arbiter_pkg;

  localparam int ADDR_W_DEFAULT       = 13;  // 8 KB video RAM
  localparam int DATA_W_DEFAULT       = 8;
  localparam int STARVE_LIMIT_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_VID_ADDR = 3'd1,
    ST_VID_DATA = 3'd2,
    ST_CPU_ADDR = 3'd3,
    ST_CPU_DATA = 3'd4
  } arb_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// Shares the single-port video RAM between the VGA byte fetcher and the CPU.
// Video fetches win by default; a CPU request that has waited STARVE_LIMIT
// cycles beats a pending fetch. Each access takes an address cycle and a data
// cycle, and the result is presented one cycle after the data cycle.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              vid_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t        state, state_nxt;
  logic              vid_pend;
  logic [ADDR_W-1:0] vid_pend_addr;
  logic [CNT_W-1:0]  starve_cnt;
  logic              cpu_is_read;

  // The ack cycle masks cpu_req so a request still held high while its own
  // ack is on the bus is not granted a second time.
  logic cpu_want, vid_want, cpu_starved, enter_vid, enter_cpu, cpu_owns_ram;
  assign cpu_want     = cpu_req & ~cpu_ack;
  assign vid_want     = vid_pend | vid_req;
  assign cpu_starved  = (starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign enter_vid    = (state_nxt == ST_VID_ADDR);
  assign enter_cpu    = (state_nxt == ST_CPU_ADDR);
  assign cpu_owns_ram = (state == ST_CPU_ADDR) || (state == ST_CPU_DATA);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of statement order.
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Grant decision and state sequencing.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nxt
    // unassigned and infers a latch.
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_VID_DATA: begin
        if (cpu_starved && cpu_want) state_nxt = ST_CPU_ADDR;
        else if (vid_want)           state_nxt = ST_VID_ADDR;
        else if (cpu_want)           state_nxt = ST_CPU_ADDR;
        else                         state_nxt = ST_IDLE;
      end
      ST_VID_ADDR: state_nxt = ST_VID_DATA;
      ST_CPU_ADDR: state_nxt = ST_CPU_DATA;
      // Never straight back to the CPU: a fetch may be waiting behind it.
      ST_CPU_DATA: state_nxt = vid_want ? ST_VID_ADDR : ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Video pending latch: the newest address wins, a replaced one is an overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_pend      <= 1'b0;
      vid_pend_addr <= '0;
      vid_overrun   <= 1'b0;
    end else if (enter_vid) begin
      // A pending address is issued now; a strobe in this cycle stays queued.
      vid_pend <= vid_pend & vid_req;
      if (vid_req) vid_pend_addr <= vid_addr;
    end else if (vid_req) begin
      vid_pend      <= 1'b1;
      vid_pend_addr <= vid_addr;
      if (vid_pend) vid_overrun <= 1'b1;
    end
  end

  // Registered RAM port, loaded on entry to an address cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
      cpu_is_read <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (enter_vid) begin
        ram_addr <= vid_pend ? vid_pend_addr : vid_addr;
      end else if (enter_cpu) begin
        ram_addr    <= cpu_addr;
        ram_we      <= cpu_we;
        ram_wdata   <= cpu_wdata;
        cpu_is_read <= ~cpu_we;
      end
    end
  end

  // CPU starvation counter, saturating at STARVE_LIMIT.
  always_ff @(posedge clk) begin
    if (reset)                                        starve_cnt <= '0;
    else if (enter_cpu)                               starve_cnt <= '0;
    else if (cpu_req && !cpu_owns_ram && !cpu_starved) starve_cnt <= starve_cnt + 1'b1;
  end

  // Result capture in the data cycle; valid/ack pulse the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_valid <= 1'b0;
      vid_data  <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      vid_valid <= (state == ST_VID_DATA);
      cpu_ack   <= (state == ST_CPU_DATA);
      if (state == ST_VID_DATA)                vid_data  <= ram_rdata;
      if (state == ST_CPU_DATA && cpu_is_read) cpu_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a synchronous RAM model, a
// transaction-level reference arbiter, directed scenarios and random traffic.
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int SL = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          vid_overrun;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_init;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_overrun(vid_overrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [7:0] init_byte(input int a);
    if (a == 'h0123) return 8'hA5;
    return 8'((a * 37) ^ (a >> 5) ^ 'h5C);
  endfunction

  // Synchronous single-port RAM, read-first, one cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_byte(i);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // ---------------- reference model ----------------
  typedef enum {OWN_VID, OWN_CPU} owner_t;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_phase;     // 0 free, 1 address cycle, 2 data cycle
  owner_t        m_own;
  bit            m_rd;
  bit            m_pend;
  logic [AW-1:0] m_pend_addr;
  int            m_starve;
  logic [DW-1:0] m_ram_out;
  logic          e_vid_valid, e_overrun, e_cpu_ack, e_ram_we;
  logic [DW-1:0] e_vid_data, e_cpu_rdata, e_ram_wdata;
  logic [AW-1:0] e_ram_addr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_valid = 0;
  int n_ack   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advances the model by one clock using the inputs the DUT samples.
  task automatic model_step();
    logic [DW-1:0] ram_now;
    bit cpu_want, vid_want, cpu_busy, fin_vid, fin_cpu;
    int grant;  // 0 none, 1 video, 2 cpu
    ram_now   = m_ram_out;
    m_ram_out = ref_mem[e_ram_addr];
    if (e_ram_we) ref_mem[e_ram_addr] = e_ram_wdata;
    if (reset) begin
      m_phase = 0; m_pend = 0; m_pend_addr = '0; m_starve = 0; m_rd = 0;
      e_vid_valid = 0; e_vid_data = '0; e_overrun = 0; e_cpu_ack = 0;
      e_cpu_rdata = '0; e_ram_addr = '0; e_ram_we = 0; e_ram_wdata = '0;
      return;
    end
    cpu_want = cpu_req && !e_cpu_ack;
    vid_want = m_pend || vid_req;
    cpu_busy = (m_phase != 0) && (m_own == OWN_CPU);
    fin_vid  = (m_phase == 2) && (m_own == OWN_VID);
    fin_cpu  = (m_phase == 2) && (m_own == OWN_CPU);
    if (m_phase == 1)  grant = 0;
    else if (fin_cpu)  grant = vid_want ? 1 : 0;
    else if (m_starve >= SL && cpu_want) grant = 2;
    else if (vid_want) grant = 1;
    else if (cpu_want) grant = 2;
    else               grant = 0;
    if (grant == 2)                                 m_starve = 0;
    else if (cpu_req && !cpu_busy && m_starve < SL) m_starve++;
    e_vid_valid = fin_vid;
    if (fin_vid) e_vid_data = ram_now;
    e_cpu_ack = fin_cpu;
    if (fin_cpu && m_rd) e_cpu_rdata = ram_now;
    e_ram_we = 0;
    if (grant == 1) begin
      e_ram_addr = m_pend ? m_pend_addr : vid_addr;
      m_pend     = m_pend && vid_req;
      if (vid_req) m_pend_addr = vid_addr;
      m_own = OWN_VID;
    end else if (vid_req) begin
      if (m_pend) e_overrun = 1;
      m_pend      = 1;
      m_pend_addr = vid_addr;
    end
    if (grant == 2) begin
      e_ram_addr  = cpu_addr;
      e_ram_we    = cpu_we;
      e_ram_wdata = cpu_wdata;
      m_rd        = !cpu_we;
      m_own       = OWN_CPU;
    end
    m_phase = (m_phase == 1) ? 2 : (grant != 0) ? 1 : 0;
  endtask

  task automatic compare_all();
    check("vid_valid",   vid_valid,   e_vid_valid);
    check("vid_data",    vid_data,    e_vid_data);
    check("vid_overrun", vid_overrun, e_overrun);
    check("cpu_ack",     cpu_ack,     e_cpu_ack);
    check("cpu_rdata",   cpu_rdata,   e_cpu_rdata);
    check("ram_we",      ram_we,      e_ram_we);
    check("ram_addr",    ram_addr,    e_ram_addr);
    check("ram_wdata",   ram_wdata,   e_ram_wdata);
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    cyc++;
    if (vid_valid) n_valid++;
    if (cpu_ack)   n_ack++;
    vid_req = 1'b0;
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input bit hold, output int lat, output logic [DW-1:0] rd);
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!cpu_ack && lat < 20);
    rd = cpu_rdata;
    if (hold) tick();
    cpu_req = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, vlat, a0, v0, nv;
    logic [DW-1:0] rd, vd;
    bit cpu_active, drop_next;
    int cpu_wait;

    reset = 1; ram_init = 1; vid_req = 0; vid_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_byte(i);
    m_ram_out = '0; m_own = OWN_VID;
    @(negedge clk);
    tick();
    ram_init = 0;
    tick();
    reset = 0;
    tick();

    // Idle video fetch.
    vid_addr = 13'h0123; vid_req = 1; lat = 0;
    do begin tick(); lat++; end while (!vid_valid && lat < 10);
    check("vid_latency", lat, 3);
    check("vid_byte", vid_data, 8'hA5);
    repeat (2) tick();

    // CPU write then read of the top address.
    cpu_access(1'b1, 13'h1FFF, 8'h5A, 1'b0, lat, rd);
    check("cpu_wr_latency", lat, 3);
    tick();
    cpu_access(1'b0, 13'h1FFF, 8'h00, 1'b1, lat, rd);
    check("cpu_rd_latency", lat, 3);
    check("cpu_rd_data", rd, 8'h5A);
    repeat (2) tick();

    // Simultaneous requests: video first, CPU ack at N+5, req held through ack.
    a0 = n_ack; vlat = -1;
    vid_addr = 13'h0040; vid_req = 1;
    cpu_we = 0; cpu_addr = 13'h0123; cpu_req = 1; lat = 0;
    do begin tick(); lat++; if (vid_valid) vlat = lat; end while (!cpu_ack && lat < 20);
    check("sim_vid_latency", vlat, 3);
    check("sim_cpu_latency", lat, 5);
    check("sim_cpu_data", cpu_rdata, 8'hA5);
    tick();
    cpu_req = 0;
    repeat (6) tick();
    check("sim_single_ack", n_ack - a0, 1);

    // Video strobes every 2 cycles with the CPU waiting.
    v0 = n_valid;
    cpu_we = 0; cpu_addr = 13'h1FFF; cpu_req = 1; lat = 0;
    do begin
      vid_req = (lat % 2 == 0); vid_addr = 13'($urandom_range(8191));
      tick(); lat++;
    end while (!cpu_ack && lat < 40);
    check("starve_grant", lat <= SL + 4, 1);
    check("starve_vid_served", (n_valid - v0) >= 3, 1);
    check("starve_rdata", cpu_rdata, 8'h5A);
    cpu_req = 0;
    repeat (6) tick();

    // Two strobes on consecutive cycles across a starved CPU grant.
    reset = 1; tick(); reset = 0; tick();
    check("ovr_after_reset", vid_overrun, 0);
    cpu_we = 0; cpu_addr = 13'h0123; cpu_req = 1; nv = 0; vd = '0;
    for (int k = 0; k < 16; k++) begin
      vid_req  = (k <= 8 && k % 2 == 0) || (k == 9);
      vid_addr = (k == 8) ? 13'h0200 : (k == 9) ? 13'h0300 : 13'($urandom_range(8191));
      tick();
      if (k + 1 >= 10 && vid_valid) begin nv++; vd = vid_data; end
      if (cpu_ack) cpu_req = 0;
    end
    check("ovr_flag", vid_overrun, 1);
    check("ovr_one_valid", nv, 1);
    check("ovr_second_addr", vd, init_byte('h0300));

    // Reset during a CPU write address cycle.
    cpu_we = 1; cpu_addr = 13'h0ABC; cpu_wdata = 8'h33; cpu_req = 1;
    tick();
    check("rst_we_before", ram_we, 1);
    reset = 1; cpu_req = 0;
    tick();
    check("rst_we_after", ram_we, 0);
    check("rst_ack", cpu_ack, 0);
    check("rst_overrun", vid_overrun, 0);
    check("rst_ram_addr", ram_addr, 0);
    reset = 0; a0 = n_ack;
    repeat (3) tick();
    check("rst_no_ack", n_ack - a0, 0);
    vid_addr = 13'h0123; vid_req = 1; lat = 0;
    do begin tick(); lat++; end while (!vid_valid && lat < 10);
    check("rst_restart_latency", lat, 3);
    check("rst_restart_data", vid_data, 8'hA5);

    // Random traffic against the model.
    cpu_active = 0; drop_next = 0; cpu_wait = 0;
    for (int n = 0; n < 3000; n++) begin
      if (drop_next) begin
        cpu_req = 0; drop_next = 0;
      end else if (cpu_active && cpu_ack) begin
        cpu_active = 0;
        if ($urandom_range(1) == 1) drop_next = 1;
        else                        cpu_req = 0;
      end
      if (!cpu_active && !drop_next && !cpu_req && $urandom_range(3) == 0) begin
        cpu_req   = 1;
        cpu_we    = 1'($urandom_range(1));
        cpu_addr  = 13'($urandom_range(31)) | ($urandom_range(1) == 1 ? 13'h1FE0 : 13'h0);
        cpu_wdata = 8'($urandom_range(255));
        cpu_active = 1; cpu_wait = 0;
      end
      if (cpu_active) begin
        cpu_wait++;
        if (cpu_wait > 60) begin
          check("cpu_timeout", cpu_wait, 0);
          cpu_active = 0; cpu_req = 0;
        end
      end
      vid_req  = ($urandom_range(4) == 0);
      vid_addr = 13'($urandom_range(31)) | ($urandom_range(1) == 1 ? 13'h1FE0 : 13'h0);
      reset    = ($urandom_range(499) == 0);
      tick();
    end
    reset = 0; cpu_req = 0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
